dm_lsm_seq: RTL and testbench
=============================

Name: dm_lsm_seq

Overview:
- Load/store-multiple sequencer for lmw/stmw; sits directly upstream of DM in the MEM stage.
- Takes one multi-word request from the pipeline and issues one word access to DM per cycle, reading GPRs for stmw and writing GPRs for lmw.
- Holds busy high while sequencing so the hazard/stall logic freezes the pipeline.

Parameters:
- ARCH_WIDTH, 32, address/data width.
- REG_ADDR_WIDTH, 5, GPR index width; last register is 2^REG_ADDR_WIDTH-1 (31).
- DMBE_WIDTH, 4, DM byte-enable width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  start request; sampled only in IDLE.
- req_load  in  1  1 = lmw, 0 = stmw.
- req_ea  in  ARCH_WIDTH  effective address of first word.
- req_reg  in  REG_ADDR_WIDTH  first register rT/rS.
- busy  out  1  sequencer active; pipeline stall.
- done  out  1  one-cycle completion pulse.
- align_err  out  1  one-cycle misaligned-request pulse (feature only).
- gpr_raddr  out  REG_ADDR_WIDTH  GPR read index (stmw).
- gpr_rdata  in  ARCH_WIDTH  GPR read data, combinational from gpr_raddr.
- gpr_we  out  1  GPR write enable (lmw).
- gpr_waddr  out  REG_ADDR_WIDTH  GPR write index.
- gpr_wdata  out  ARCH_WIDTH  GPR write data.
- dm_addr  out  ARCH_WIDTH  to DM addr.
- dm_wr  out  1  to DM wr.
- dm_be  out  [0:DMBE_WIDTH-1]  to DM BE.
- dm_din  out  ARCH_WIDTH  to DM din.
- dm_dout  in  ARCH_WIDTH  from DM dout (asynchronous read).

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE; busy, done, align_err, dm_wr, gpr_we = 0; dm_be=4'b0000; dm_addr, dm_din, gpr_raddr, gpr_waddr, gpr_wdata = 0.
- Internal registers: ea_r, cur_reg, load_r, data_r, wreg_r, wpend.
- States: IDLE, XFER, DRAIN.
- IDLE:
  - On req_valid with an accepted request: ea_r=req_ea, cur_reg=req_reg, load_r=req_load; next state XFER.
  - Request acceptance costs 1 cycle; DM is untouched in that cycle.
- XFER, every cycle:
  - dm_addr=ea_r; busy=1.
  - stmw: gpr_raddr=cur_reg, dm_din=gpr_rdata, dm_wr=1, dm_be=4'b1111.
  - lmw: dm_wr=0, dm_be=4'b0000; at the clock edge data_r<=dm_dout, wreg_r<=cur_reg, wpend<=1.
  - Then ea_r<=ea_r+4 (modulo 2^ARCH_WIDTH, wraps silently) and cur_reg<=cur_reg+1.
- lmw writeback:
  - gpr_we=wpend, gpr_waddr=wreg_r, gpr_wdata=data_r.
  - Each GPR is written exactly one cycle after its DM read.
- Leaving XFER (when cur_reg==31):
  - stmw: done=1 in this same cycle; next state IDLE.
  - lmw: next state DRAIN.
- DRAIN (lmw only): final GPR write (gpr_we=1); done=1; busy=1; next state IDLE; wpend cleared.
- Transfer count: N = 32 - req_reg words.
  - stmw busy for N cycles.
  - lmw busy for N+1 cycles.
  - busy deasserts the cycle after done.
- req_reg=31: single-word transfer. No special case needed.
- req_valid while busy: ignored; no queuing.
- rst mid-operation: next cycle is IDLE with all outputs at reset values. No further DM or GPR writes, including a pending lmw writeback, which is dropped.
- GPR read/write collisions: none internal. Register-forwarding hazards are the pipeline's responsibility (busy stalls all other GPR users).
- Byte ordering: dm_din and dm_dout pass unchanged. Endian lane mapping belongs to DM.

Optional Feature:
- Macro: LSM_ALIGN_CHK_EN.
- Defined:
  - A request with req_ea[1:0] != 2'b00 is rejected and stays in IDLE.
  - align_err=1 for exactly that cycle; no DM or GPR access; done stays 0.
- Undefined:
  - align_err is tied 0.
  - req_ea[1:0] is forced to 2'b00 when captured, so every request is accepted word-aligned.

Test Plan:
- stmw, req_reg=29, req_ea=0x0000_3000, GPR29..31=0xA,0xB,0xC:
  - dm_wr=1, BE=1111 on 3 consecutive cycles.
  - Addresses 0x3000/0x3004/0x3008, data A/B/C.
  - done with third write; busy 3 cycles.
- lmw, req_reg=30, DM[0x3010]=0x1234_5678, DM[0x3014]=0xDEAD_BEEF:
  - GPR30=0x12345678 one cycle after first read, then GPR31=0xDEADBEEF in DRAIN with done=1.
  - busy 3 cycles; dm_wr never 1.
- req_reg=31, stmw, ea=0xFFFF_FFFC: single write at 0xFFFFFFFC; done same cycle; no wrap side effects.
- rst asserted during the 2nd XFER cycle of lmw req_reg=28: next cycle IDLE, busy=0; no gpr_we thereafter; new request accepted normally afterwards.
- req_valid pulsed while busy with a different req_reg: ignored; original sequence completes unchanged.
- LSM_ALIGN_CHK_EN defined, req_ea=0x3002: align_err=1 one cycle, busy=0, no dm_wr/gpr_we. Undefined: access proceeds at 0x3000.

Source files
------------

// File: rtl/dm_lsm_seq.sv
// Load/store-multiple sequencer: turns one lmw/stmw request into one DM word access per cycle.
// Optional macro LSM_ALIGN_CHK_EN rejects misaligned requests with an align_err pulse.
module dm_lsm_seq #(
  parameter int ARCH_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DMBE_WIDTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic                      req_load,
  input  logic [ARCH_WIDTH-1:0]     req_ea,
  input  logic [REG_ADDR_WIDTH-1:0] req_reg,
  output logic                      busy,
  output logic                      done,
  output logic                      align_err,
  output logic [REG_ADDR_WIDTH-1:0] gpr_raddr,
  input  logic [ARCH_WIDTH-1:0]     gpr_rdata,
  output logic                      gpr_we,
  output logic [REG_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [ARCH_WIDTH-1:0]     gpr_wdata,
  output logic [ARCH_WIDTH-1:0]     dm_addr,
  output logic                      dm_wr,
  output logic [0:DMBE_WIDTH-1]     dm_be,
  output logic [ARCH_WIDTH-1:0]     dm_din,
  input  logic [ARCH_WIDTH-1:0]     dm_dout
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN} state_t;

  localparam logic [REG_ADDR_WIDTH-1:0] LAST_REG = {REG_ADDR_WIDTH{1'b1}};

  state_t                      r_state;
  state_t                      w_state_next;
  logic [ARCH_WIDTH-1:0]       r_ea;
  logic [REG_ADDR_WIDTH-1:0]   r_cur_reg;
  logic                        r_load;
  logic [ARCH_WIDTH-1:0]       r_data;
  logic [REG_ADDR_WIDTH-1:0]   r_wreg;
  logic                        r_wpend;
  logic                        w_misaligned;
  logic                        w_accept;
  logic                        w_last;

`ifdef LSM_ALIGN_CHK_EN
  assign w_misaligned = (req_ea[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && req_valid && !w_misaligned;
  assign w_last   = (r_cur_reg == LAST_REG);

  // Writeback lags its DM read by one cycle, straight from the pending registers.
  assign gpr_we    = r_wpend;
  assign gpr_waddr = r_wreg;
  assign gpr_wdata = r_data;

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    align_err    = 1'b0;
    gpr_raddr    = '0;
    dm_addr      = '0;
    dm_wr        = 1'b0;
    dm_be        = '0;
    dm_din       = '0;
    case (r_state)
      S_IDLE: begin
        align_err = req_valid && w_misaligned;
        if (w_accept) w_state_next = S_XFER;
      end
      S_XFER: begin
        busy    = 1'b1;
        dm_addr = r_ea;
        if (!r_load) begin
          gpr_raddr = r_cur_reg;
          dm_din    = gpr_rdata;
          dm_wr     = 1'b1;
          dm_be     = '1;
        end
        if (w_last) begin
          if (r_load) begin
            w_state_next = S_DRAIN;
          end else begin
            done         = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ea      <= '0;
      r_cur_reg <= '0;
      r_load    <= 1'b0;
      r_data    <= '0;
      r_wreg    <= '0;
      r_wpend   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Low address bits are dropped so every accepted request is word aligned.
            r_ea      <= req_ea & ~ARCH_WIDTH'(3);
            r_cur_reg <= req_reg;
            r_load    <= req_load;
          end
        end
        S_XFER: begin
          r_ea      <= r_ea + ARCH_WIDTH'(4);
          r_cur_reg <= r_cur_reg + REG_ADDR_WIDTH'(1);
          if (r_load) begin
            r_data  <= dm_dout;
            r_wreg  <= r_cur_reg;
            r_wpend <= 1'b1;
          end else begin
            r_wpend <= 1'b0;
          end
        end
        S_DRAIN: r_wpend <= 1'b0;
        default: r_wpend <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsm_seq.sv
// Scoreboard bench for dm_lsm_seq: expected DM and GPR writes are queued when a request
// is driven and popped as the DUT performs them.
module tb_dm_lsm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_load;
  logic [31:0] req_ea;
  logic [4:0]  req_reg;
  logic        busy;
  logic        done;
  logic        align_err;
  logic [4:0]  gpr_raddr;
  logic [31:0] gpr_rdata;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [31:0] dm_addr;
  logic        dm_wr;
  logic [0:3]  dm_be;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;

  logic [31:0] gpr [32];
  logic [31:0] dm_mem [64];
  logic [63:0] dm_q [$];
  logic [63:0] gpr_q [$];
  logic [63:0] mon_e;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  dm_lsm_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_load(req_load),
    .req_ea(req_ea), .req_reg(req_reg), .busy(busy), .done(done),
    .align_err(align_err), .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .dm_addr(dm_addr), .dm_wr(dm_wr), .dm_be(dm_be), .dm_din(dm_din),
    .dm_dout(dm_dout)
  );

  assign gpr_rdata = gpr[gpr_raddr];
  assign dm_dout   = dm_mem[dm_addr[7:2]];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Every DM write and GPR write must match the head of its queue.
  always @(negedge clk) begin
    if (dm_wr) begin
      if (dm_q.size() == 0) begin
        check_val("dm_unexpected_wr", {32'd0, dm_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = dm_q.pop_front();
        check_val("dm_wr_addr_data", {dm_addr, dm_din}, mon_e);
        check_val("dm_be", {60'd0, dm_be}, 64'hF);
      end
    end
    if (gpr_we) begin
      if (gpr_q.size() == 0) begin
        check_val("gpr_unexpected_we", {59'd0, gpr_waddr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = gpr_q.pop_front();
        check_val("gpr_wr_idx_data", {27'd0, gpr_waddr, gpr_wdata}, mon_e);
      end
    end
  end

  task automatic do_req(input logic ld, input logic [31:0] ea, input logic [4:0] rg, input bit pulse);
    int          n;
    int          cyc;
    bit          seen;
    logic [31:0] a;
    n    = 32 - int'(rg);
    cyc  = 0;
    seen = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_load  = ld;
    req_ea    = ea;
    req_reg   = rg;
    for (int i = 0; i < n; i++) begin
      a = (ea & 32'hFFFF_FFFC) + 32'(4 * i);
      if (ld) gpr_q.push_back({27'd0, 5'(int'(rg) + i), dm_mem[a[7:2]]});
      else    dm_q.push_back({a, gpr[5'(int'(rg) + i)]});
    end
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (pulse && k == 1) begin
        req_valid = 1'b1;
        req_reg   = rg ^ 5'd3;
        req_ea    = 32'h0000_0100;
      end else begin
        req_valid = 1'b0;
      end
      if (busy) cyc++;
      if (done) begin
        seen = 1;
        check_val("done_with_busy", {63'd0, busy}, 64'd1);
        check_val("done_with_last_wr", {63'd0, ld ? gpr_we : dm_wr}, 64'd1);
      end
    end
    req_valid = 1'b0;
    check_val("done_seen", {63'd0, seen}, 64'd1);
    check_val("busy_cycles", 64'(cyc), ld ? 64'(n + 1) : 64'(n));
    @(negedge clk);
    check_val("busy_after_done", {63'd0, busy}, 64'd0);
    check_val("done_one_pulse", {63'd0, done}, 64'd0);
    check_val("dm_q_drained", 64'(dm_q.size()), 64'd0);
    check_val("gpr_q_drained", 64'(gpr_q.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = $urandom;
    for (int i = 0; i < 64; i++) dm_mem[i] = $urandom;
    gpr[29] = 32'hA;
    gpr[30] = 32'hB;
    gpr[31] = 32'hC;
    dm_mem[4] = 32'h1234_5678;
    dm_mem[5] = 32'hDEAD_BEEF;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_ea    = '0;
    req_reg   = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_dm_wr", {63'd0, dm_wr}, 64'd0);
    check_val("rst_gpr_we", {63'd0, gpr_we}, 64'd0);
    check_val("rst_dm_be", {60'd0, dm_be}, 64'd0);
    check_val("rst_dm_addr", {32'd0, dm_addr}, 64'd0);
    check_val("rst_gpr_waddr", {59'd0, gpr_waddr}, 64'd0);
    check_val("rst_align_err", {63'd0, align_err}, 64'd0);
    rst = 1'b0;

    do_req(1'b0, 32'h0000_3000, 5'd29, 1'b0);
    do_req(1'b1, 32'h0000_3010, 5'd30, 1'b0);
    do_req(1'b0, 32'hFFFF_FFFC, 5'd31, 1'b0);

    // Reset lands in the second XFER cycle of an lmw; only the first writeback may appear.
    @(negedge clk);
    req_valid = 1'b1;
    req_load  = 1'b1;
    req_ea    = 32'h0000_3020;
    req_reg   = 5'd28;
    gpr_q.push_back({27'd0, 5'd28, dm_mem[8]});
    @(negedge clk);
    req_valid = 1'b0;
    check_val("abort_busy_xfer1", {63'd0, busy}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_busy_idle", {63'd0, busy}, 64'd0);
    check_val("abort_gpr_we", {63'd0, gpr_we}, 64'd0);
    check_val("abort_dm_addr", {32'd0, dm_addr}, 64'd0);
    repeat (4) @(negedge clk);
    check_val("abort_busy_later", {63'd0, busy}, 64'd0);
    check_val("abort_gpr_q", 64'(gpr_q.size()), 64'd0);

    do_req(1'b1, 32'h0000_3020, 5'd28, 1'b0);
    do_req(1'b0, 32'h0000_3100, 5'd26, 1'b1);
    do_req(1'b1, 32'h0000_3000, 5'd25, 1'b1);

`ifdef LSM_ALIGN_CHK_EN
    @(negedge clk);
    req_valid = 1'b1;
    req_load  = 1'b0;
    req_ea    = 32'h0000_3002;
    req_reg   = 5'd31;
    #1;
    check_val("align_err_pulse", {63'd0, align_err}, 64'd1);
    check_val("align_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check_val("align_err_clear", {63'd0, align_err}, 64'd0);
    check_val("align_busy_after", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    check_val("align_done", {63'd0, done}, 64'd0);
`else
    do_req(1'b0, 32'h0000_3002, 5'd31, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
